// File: rtl/io_sel_ctrl.sv
// io_sel_ctrl: bus-programmable pad function selector. Every change is applied
// as hi-Z guard -> io_sel switch -> settle guard, so that only the pads whose
// selection actually changes are ever floated.

// Per-pin slice: holds one applied io_sel bit and its hi-Z force bit.
module io_sel_pin (
   input  logic clk,
   input  logic reset_n,
   input  logic rst_val_i,   // io_sel value after reset
   input  logic launch_i,    // sequence starts: load hi-Z from diff
   input  logic diff_i,      // this pin changes in the launching sequence
   input  logic apply_i,     // SWITCH cycle: take the target selection
   input  logic tgt_i,       // target selection bit
   input  logic finish_i,    // last SETTLE cycle: release hi-Z
   output logic sel_o,
   output logic hiz_o
);

   logic sel_q, sel_d;
   logic hiz_q, hiz_d;

   // Next state: selection only moves on apply, hi-Z is held for the whole sequence
   always_comb begin
      sel_d = sel_q;
      hiz_d = hiz_q;
      if (apply_i)
         sel_d = tgt_i;
      if (launch_i)
         hiz_d = diff_i;
      else if (finish_i)
         hiz_d = 1'b0;
   end

   // Pin state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sel_q <= rst_val_i;
         hiz_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
         hiz_q <= hiz_d;
      end
   end

   assign sel_o = sel_q;
   assign hiz_o = hiz_q;

endmodule

module io_sel_ctrl #(
   parameter int                N_PINS       = 15,
   parameter int                GUARD_CYCLES = 4,
   parameter logic [N_PINS-1:0] SEL_RST      = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sel_i,
   input  logic              we_i,
   input  logic [1:0]        addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              ack_o,
   output logic [N_PINS-1:0] io_sel_o,
   output logic [N_PINS-1:0] pad_hiz_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HIZ    = 2'd1,
      S_SWITCH = 2'd2,
      S_SETTLE = 2'd3
   } state_e;

   localparam logic [1:0] A_REQ    = 2'd0;
   localparam logic [1:0] A_ACTIVE = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_LOCK   = 2'd3;

   // Both guards share one counter, reloaded on entry to HIZ and SETTLE
   localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES - 1);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [N_PINS-1:0] req_q, req_d;
   logic [N_PINS-1:0] diff_q, diff_d;
   logic [N_PINS-1:0] tgt_q, tgt_d;
   logic              lock_q, lock_d;
   logic              pend_q, pend_d;
   logic              ack_q, ack_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [N_PINS-1:0] io_sel;
   logic [N_PINS-1:0] pad_hiz;
   logic              launch, apply, finish, pend_clr;
   logic              req_wr, lock_wr;
   logic [31:0]       rd_mux;
   logic              unused_wdata;

   assign unused_wdata = ^wdata_i;

   // Sequencer next state: launch from IDLE, time guards, apply in SWITCH
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      tgt_d    = tgt_q;
      launch   = 1'b0;
      apply    = 1'b0;
      finish   = 1'b0;
      pend_clr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               pend_clr = 1'b1;
               // A pending request equal to the applied value is a no-op
               if (req_q != io_sel) begin
                  diff_d  = req_q ^ io_sel;
                  tgt_d   = req_q;
                  cnt_d   = GUARD_LD;
                  launch  = 1'b1;
                  state_d = S_HIZ;
               end
            end
         end
         S_HIZ: begin
            if (cnt_q == 8'd0)
               state_d = S_SWITCH;
            else
               cnt_d = cnt_q - 8'd1;
         end
         S_SWITCH: begin
            apply   = 1'b1;
            cnt_d   = GUARD_LD;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == 8'd0) begin
               finish  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bus side: register writes, read mux and registered ack/rdata
   always_comb begin
      req_wr  = sel_i && we_i && (addr_i == A_REQ) && !lock_q;
      lock_wr = sel_i && we_i && (addr_i == A_LOCK) && wdata_i[0];

      req_d  = req_wr ? wdata_i[N_PINS-1:0] : req_q;
      lock_d = lock_q | lock_wr;
      // A write in the launch cycle re-arms pend for the newer request
      if (req_wr)
         pend_d = 1'b1;
      else if (pend_clr)
         pend_d = 1'b0;
      else
         pend_d = pend_q;

      rd_mux = '0;
      case (addr_i)
         A_REQ:    rd_mux[N_PINS-1:0] = req_q;
         A_ACTIVE: rd_mux[N_PINS-1:0] = io_sel;
         A_STATUS: rd_mux[2:0]        = {pend_q, lock_q, busy_o};
         A_LOCK:   rd_mux[0]          = lock_q;
         default:  rd_mux             = '0;
      endcase

      ack_d   = sel_i;
      rdata_d = (sel_i && !we_i) ? rd_mux : '0;
   end

   // Control and bus registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= SEL_RST;
         diff_q  <= '0;
         tgt_q   <= SEL_RST;
         lock_q  <= 1'b0;
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         diff_q  <= diff_d;
         tgt_q   <= tgt_d;
         lock_q  <= lock_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   // One slice per shared pin; hi-Z loads the freshly computed diff at launch
   for (genvar p = 0; p < N_PINS; p++) begin : g_pin
      io_sel_pin u_pin (
         .clk       (clk),
         .reset_n   (reset_n),
         .rst_val_i (SEL_RST[p]),
         .launch_i  (launch),
         .diff_i    (diff_d[p]),
         .apply_i   (apply),
         .tgt_i     (tgt_q[p]),
         .finish_i  (finish),
         .sel_o     (io_sel[p]),
         .hiz_o     (pad_hiz[p])
      );
   end

   assign busy_o    = (state_q != S_IDLE);
   assign io_sel_o  = io_sel;
   assign pad_hiz_o = pad_hiz;
   assign ack_o     = ack_q;
   assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_io_sel_ctrl.sv
// Bench for io_sel_ctrl: directed scenarios followed by random bus traffic,
// every cycle compared against a transaction-level model of the controller.
module tb_io_sel_ctrl;

   localparam int N = 15;
   localparam int G = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          sel_i = 1'b0;
   logic          we_i = 1'b0;
   logic [1:0]    addr_i = 2'd0;
   logic [31:0]   wdata_i = 32'd0;
   logic [31:0]   rdata_o;
   logic          ack_o;
   logic [N-1:0]  io_sel_o;
   logic [N-1:0]  pad_hiz_o;
   logic          busy_o;

   always #5 clk = ~clk;

   io_sel_ctrl #(.N_PINS(N), .GUARD_CYCLES(G), .SEL_RST('0)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sel_i     (sel_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .rdata_o   (rdata_o),
      .ack_o     (ack_o),
      .io_sel_o  (io_sel_o),
      .pad_hiz_o (pad_hiz_o),
      .busy_o    (busy_o)
   );

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   int hiz_cnt = 0;
   int chg_cyc = 0;
   int busy_seen = 0;
   int ack_c = 0;

   // Model: requested/applied values plus "edges since launch" of a running sequence
   logic [N-1:0] m_req, m_act, m_diff, m_tgt;
   bit           m_lock, m_pend, m_run;
   int           m_k;
   bit           exp_ack;
   logic [31:0]  exp_rd;

   function automatic void model_edge(input logic s, input logic w, input logic [1:0] a,
                                      input logic [31:0] d, input logic r);
      if (!r) begin
         m_req = '0; m_act = '0; m_diff = '0; m_tgt = '0;
         m_lock = 0; m_pend = 0; m_run = 0; m_k = 0;
         exp_ack = 0; exp_rd = '0;
         return;
      end
      exp_ack = s;
      exp_rd  = '0;
      if (s && !w) begin
         case (a)
            2'd0: exp_rd = 32'(m_req);
            2'd1: exp_rd = 32'(m_act);
            2'd2: exp_rd = {29'd0, m_pend, m_lock, m_run};
            default: exp_rd = {31'd0, m_lock};
         endcase
      end
      // Sequence: hi-Z over edges 0..2G after launch, new value lands on edge G+1
      if (m_run) begin
         m_k++;
         if (m_k == G + 1) m_act = m_tgt;
         if (m_k == 2 * G + 1) m_run = 0;
      end else if (m_pend) begin
         m_pend = 0;
         if (m_req != m_act) begin
            m_run = 1; m_k = 0; m_diff = m_req ^ m_act; m_tgt = m_req;
         end
      end
      if (s && w) begin
         if (a == 2'd0 && !m_lock) begin
            m_req  = d[N-1:0];
            m_pend = 1;
         end else if (a == 2'd3 && d[0]) begin
            m_lock = 1;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic s, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic r);
      logic [N-1:0] prev;
      reset_n = r; sel_i = s; we_i = w; addr_i = a; wdata_i = d;
      prev = io_sel_o;
      @(posedge clk);
      model_edge(s, w, a, d, r);
      #1;
      cyc_n++;
      if (io_sel_o !== prev) chg_cyc = cyc_n;
      if (pad_hiz_o != '0) hiz_cnt++;
      if (busy_o) busy_seen++;
      chk("ack", 32'(ack_o), 32'(exp_ack));
      chk("rdata", rdata_o, exp_rd);
      chk("io_sel", 32'(io_sel_o), 32'(m_act));
      chk("pad_hiz", 32'(pad_hiz_o), 32'(m_run ? m_diff : '0));
      chk("busy", 32'(busy_o), 32'(m_run));
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      step(1'b1, 1'b1, a, d, 1'b1);
   endtask

   task automatic rd(input logic [1:0] a);
      step(1'b1, 1'b0, a, 32'd0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
   endtask

   task automatic rst_pulse();
      step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
   endtask

   initial begin
      logic s, w, r;
      logic [1:0] a;
      logic [31:0] d;

      // T1 reset
      rst_pulse();
      rst_pulse();
      chk("T1_io_sel", 32'(io_sel_o), 32'd0);
      chk("T1_pad_hiz", 32'(pad_hiz_o), 32'd0);
      rd(2'd2);
      chk("T1_status", rdata_o, 32'd0);

      // T2 full switch 0 -> 0x0005
      hiz_cnt = 0;
      wr(2'd0, 32'h5);
      ack_c = cyc_n;
      idle(2 * G + 4);
      chk("T2_hiz_cycles", 32'(hiz_cnt), 32'(2 * G + 1));
      chk("T2_latency", 32'(chg_cyc - ack_c), 32'(G + 2));
      chk("T2_io_sel", 32'(io_sel_o), 32'h5);

      // T3 partial change 0x0005 -> 0x0006 floats only bits 0 and 1
      wr(2'd0, 32'h6);
      idle(2);
      chk("T3_pad_hiz", 32'(pad_hiz_o), 32'h3);
      idle(2 * G + 2);
      rd(2'd1);
      chk("T3_active", rdata_o, 32'h6);

      // T4 second request while busy
      wr(2'd0, 32'h100);
      idle(3);
      wr(2'd0, 32'h200);
      rd(2'd2);
      chk("T4_status", rdata_o, 32'h5);
      idle(2 * G);
      chk("T4_first", 32'(io_sel_o), 32'h100);
      idle(G + 1);
      chk("T4_second_hiz", 32'(pad_hiz_o), 32'h300);
      idle(2 * G + 2);
      rd(2'd1);
      chk("T4_active", rdata_o, 32'h200);

      // T5 lock blocks REQ writes until reset
      wr(2'd3, 32'h1);
      busy_seen = 0;
      wr(2'd0, 32'h7FFF);
      chk("T5_ack", 32'(ack_o), 32'd1);
      idle(3);
      chk("T5_no_seq", 32'(busy_seen), 32'd0);
      rd(2'd0);
      chk("T5_req", rdata_o, 32'h200);
      rd(2'd2);
      chk("T5_status", rdata_o, 32'h2);
      rst_pulse();
      rd(2'd2);
      chk("T5_status_rst", rdata_o, 32'h0);

      // T6 reset in the second HIZ cycle
      wr(2'd0, 32'hA);
      idle(2);
      chk("T6_in_hiz", 32'(pad_hiz_o), 32'hA);
      rst_pulse();
      chk("T6_io_sel", 32'(io_sel_o), 32'd0);
      chk("T6_pad_hiz", 32'(pad_hiz_o), 32'd0);
      chk("T6_busy", 32'(busy_o), 32'd0);

      // T7 request equal to the applied value
      busy_seen = 0;
      hiz_cnt = 0;
      wr(2'd0, 32'h0);
      idle(4);
      chk("T7_busy", 32'(busy_seen), 32'd0);
      chk("T7_hiz", 32'(hiz_cnt), 32'd0);
      rd(2'd2);
      chk("T7_status", rdata_o, 32'd0);

      // Random traffic: mostly REQ writes and reads, rare lock and reset
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 99) != 0);
         s = ($urandom_range(0, 2) == 0);
         w = $urandom_range(0, 1) == 1;
         a = 2'($urandom_range(0, 3));
         d = $urandom;
         if (a == 2'd3 && w) d[0] = ($urandom_range(0, 15) == 0);
         if (a == 2'd0 && w && $urandom_range(0, 3) == 0) d = 32'(m_act);
         step(s, w, a, d, r);
      end
      idle(2 * G + 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
